// File: rtl/cache_line_axi_master_if.sv
// AXI4 master-side bus bundle for the cache line port.
// Carries AR/R/AW/W/B channels; rid/bid are carried but unused by the master.
interface cache_line_axi_master_if #(
  parameter int ID_WIDTH = 4
);
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;
  logic                arvalid;
  logic                arready;

  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic [ID_WIDTH-1:0] rid;
  logic                rready;

  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [ID_WIDTH-1:0] awid;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic [ID_WIDTH-1:0] wid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic [ID_WIDTH-1:0] bid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid, rid,
    output rready,
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid, wid,
    input  wready,
    input  bresp, bvalid, bid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid, rid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid, wid,
    output wready,
    output bresp, bvalid, bid,
    input  bready
  );
endinterface

// File: rtl/cache_line_axi_master.sv
// Cache line refill / posted write-back AXI4 master.
// Define CACHE_LINE_AXI_WRAP_EN for critical-word-first WRAP refills.
module cache_line_axi_master #(
  parameter int LINE_WORDS = 4,
  parameter int WB_DEPTH   = 2,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  output logic                    ret_err,
  output logic                    crit_valid,
  output logic [31:0]             crit_data,
  input  logic                    wr_req,
  input  logic [31:0]             wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    wb_empty,
  output logic                    bus_err,
  cache_line_axi_master_if.master m_axi
);
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;
  localparam int TW  = 32 - OFF;
  localparam int PW  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int NW  = $clog2(WB_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_DATA, R_DONE
  } r_state_e;
  typedef enum logic [1:0] {
    W_IDLE, W_AW, W_DATA, W_RESP
  } w_state_e;

  r_state_e      r_state_q, r_state_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [CW-1:0] rn_q, rn_d;
  logic [CW-1:0] roff_q, roff_d;
  logic [CW-1:0] slot;
  logic          rerr_q, rerr_d;
  line_t         line_q, line_d;

  w_state_e      w_state_q, w_state_d;
  logic [CW-1:0] wbeat_q, wbeat_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [WB_DEPTH-1:0] vld_q, vld_d;
  logic [TW-1:0] tag_q [WB_DEPTH];
  logic [TW-1:0] tag_d [WB_DEPTH];
  line_t         buf_q [WB_DEPTH];
  line_t         buf_d [WB_DEPTH];
  logic          bus_err_q, bus_err_d;
  logic          hazard, push, pop;
  logic          unused_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Refill must not overtake a buffered or same-cycle write of its line.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (vld_q[i] && tag_q[i] == rd_addr[31:OFF])
        hazard = 1'b1;
    end
    if (push && wr_addr[31:OFF] == rd_addr[31:OFF])
      hazard = 1'b1;
  end

  always_comb begin
    r_state_d     = r_state_q;
    raddr_d       = raddr_q;
    rn_d          = rn_q;
    roff_d        = roff_q;
    rerr_d        = rerr_q;
    line_d        = line_q;
    rd_rdy        = 1'b0;
    ret_valid     = 1'b0;
    crit_valid    = 1'b0;
    crit_data     = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    slot          = rn_q + roff_q;
    unique case (r_state_q)
      R_IDLE: begin
        rd_rdy = !hazard;
        if (rd_req && !hazard) begin
          r_state_d = R_AR;
          raddr_d   = rd_addr;
          rn_d      = '0;
          rerr_d    = 1'b0;
`ifdef CACHE_LINE_AXI_WRAP_EN
          roff_d    = rd_addr[OFF-1:2];
`else
          roff_d    = '0;
`endif
        end
      end
      R_AR: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready)
          r_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) begin
          line_d[slot] = m_axi.rdata;
          rn_d = rn_q + 1'b1;
          if (m_axi.rresp != 2'b00 ||
              m_axi.rlast != (rn_q == LAST))
            rerr_d = 1'b1;
          if (rn_q == LAST)
            r_state_d = R_DONE;
`ifdef CACHE_LINE_AXI_WRAP_EN
          if (rn_q == '0) begin
            crit_valid = 1'b1;
            crit_data  = m_axi.rdata;
          end
`endif
        end
      end
      R_DONE: begin
        ret_valid = 1'b1;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d     = w_state_q;
    wbeat_d       = wbeat_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    vld_d         = vld_q;
    tag_d         = tag_q;
    buf_d         = buf_q;
    bus_err_d     = bus_err_q;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    pop           = 1'b0;
    push          = wr_req && wr_rdy;
    unique case (w_state_q)
      W_IDLE: begin
        if (cnt_q != '0)
          w_state_d = W_AW;
      end
      W_AW: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready)
          w_state_d = W_DATA;
      end
      W_DATA: begin
        m_axi.wvalid = 1'b1;
        if (m_axi.wready) begin
          wbeat_d = wbeat_q + 1'b1;
          if (wbeat_q == LAST)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          pop = 1'b1;
          if (m_axi.bresp != 2'b00)
            bus_err_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (push) begin
      tag_d[wptr_q] = wr_addr[31:OFF];
      buf_d[wptr_q] = wr_data;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = nxt(wptr_q);
    end
    // Head leaves the buffer only once its B response is in.
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = nxt(rptr_q);
    end
    cnt_d = cnt_q + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rn_q      <= '0;
      roff_q    <= '0;
      rerr_q    <= 1'b0;
      line_q    <= '0;
      w_state_q <= W_IDLE;
      wbeat_q   <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      vld_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rn_q      <= rn_d;
      roff_q    <= roff_d;
      rerr_q    <= rerr_d;
      line_q    <= line_d;
      w_state_q <= w_state_d;
      wbeat_q   <= wbeat_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      vld_q     <= vld_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    buf_q <= buf_d;
  end

  assign ret_data = line_q;
  assign ret_err  = rerr_q && (r_state_q == R_DONE);
  assign wr_rdy   = cnt_q < NW'(WB_DEPTH);
  assign wb_empty = (cnt_q == '0) && (w_state_q == W_IDLE);
  assign bus_err  = bus_err_q;

`ifdef CACHE_LINE_AXI_WRAP_EN
  assign m_axi.araddr  = {raddr_q[31:2], 2'b00};
  assign m_axi.arburst = 2'b10;
`else
  assign m_axi.araddr  = {raddr_q[31:OFF], {OFF{1'b0}}};
  assign m_axi.arburst = 2'b01;
`endif
  assign m_axi.arlen   = 8'(LINE_WORDS - 1);
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arid    = ID_WIDTH'(AXI_ID);

  assign m_axi.awaddr  = {tag_q[rptr_q], {OFF{1'b0}}};
  assign m_axi.awlen   = 8'(LINE_WORDS - 1);
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.wdata   = buf_q[rptr_q][wbeat_q];
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = (w_state_q == W_DATA) &&
                         (wbeat_q == LAST);
  assign m_axi.wid     = ID_WIDTH'(AXI_ID);

  assign unused_ok = ^{m_axi.rid, m_axi.bid,
                       raddr_q[1:0], rd_addr[1:0],
                       wr_addr[OFF-1:0]};
endmodule

// File: tb/tb_cache_line_axi_master.sv
// Randomized bench for cache_line_axi_master with AXI slave model.
// Honours CACHE_LINE_AXI_WRAP_EN when defined for the DUT as well.
module tb_cache_line_axi_master;
  localparam int LW    = 4;
  localparam int DEPTH = 2;
  localparam int DW    = 32 * LW;
  localparam logic [31:0] LMASK = 32'(DW / 8 - 1);
`ifdef CACHE_LINE_AXI_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [31:0]   rd_addr;
  logic          rd_rdy;
  logic          ret_valid;
  logic [DW-1:0] ret_data;
  logic          ret_err;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          wr_req;
  logic [31:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy;
  logic          wb_empty;
  logic          bus_err;

  cache_line_axi_master_if #(.ID_WIDTH(4)) axi ();

  cache_line_axi_master #(
    .LINE_WORDS(LW),
    .WB_DEPTH(DEPTH),
    .ID_WIDTH(4),
    .AXI_ID(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_rdy(rd_rdy),
    .ret_valid(ret_valid),
    .ret_data(ret_data),
    .ret_err(ret_err),
    .crit_valid(crit_valid),
    .crit_data(crit_data),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_rdy(wr_rdy),
    .wb_empty(wb_empty),
    .bus_err(bus_err),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } ret_t;

  int            checks = 0;
  int            passed = 0;
  logic [31:0]   rq_addr [$];
  ret_t          ret_q [$];
  logic [31:0]   wpend_tag [$];
  logic [DW-1:0] wpend_data [$];
  logic          exp_bus_err = 1'b0;
  bit            rd_busy = 1'b0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h3000_0000 + 32'($urandom_range(0, 3) * 16)
           + 32'($urandom_range(0, 15));
  endfunction

  // One cycle of cache-side observation, at #1 after the negedge drive.
  task automatic step_obs();
    bit hit;
    bit exp_wr;
    hit = 1'b0;
    exp_wr = (wpend_tag.size() < DEPTH);
    foreach (wpend_tag[i])
      if (wpend_tag[i] == (rd_addr & ~LMASK)) hit = 1'b1;
    if (wr_req && exp_wr &&
        (wr_addr & ~LMASK) == (rd_addr & ~LMASK))
      hit = 1'b1;
    chk("rd_rdy", rd_rdy, !rd_busy && !hit);
    chk("wr_rdy", wr_rdy, exp_wr);
    chk("wb_empty", wb_empty, wpend_tag.size() == 0);
    chk("bus_err", bus_err, exp_bus_err);
    if (rd_req && rd_rdy) begin
      rd_busy = 1'b1;
      rq_addr.push_back(rd_addr);
    end
    if (wr_req && wr_rdy) begin
      wpend_tag.push_back(wr_addr & ~LMASK);
      wpend_data.push_back(wr_data);
    end
    if (ret_valid) rd_busy = 1'b0;
  endtask

  initial begin : r_slave
    bit          act;
    bit          pend;
    int          beat;
    int          off;
    int          mode;
    int          ebeat;
    logic [31:0] a;
    logic [31:0] line;
    ret_t        e;
    act = 0; pend = 0; beat = 0; off = 0;
    mode = 0; ebeat = 0; line = '0; a = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rid     = 4'd1;
    forever begin
      @(negedge clk);
      axi.arready = ($urandom_range(0, 2) != 0);
      if (!pend && act && beat < LW &&
          $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        axi.rdata = mem_word(line + 32'(4 * ((off + beat) % LW)));
        axi.rresp = (mode == 3 && beat == ebeat) ? 2'b10 : 2'b00;
        if (mode == 4) axi.rlast = (beat == ebeat);
        else if (mode == 5) axi.rlast = 1'b0;
        else axi.rlast = (beat == LW - 1);
      end
      axi.rvalid = pend;
      #1;
      if (axi.rvalid && axi.rready) begin
        chk("crit_valid", crit_valid, WRAP && beat == 0);
        if (WRAP && beat == 0)
          chk("crit_data", crit_data, mem_word(line + 32'(4 * off)));
        pend = 1'b0;
        beat++;
        if (beat == LW) act = 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        chk("ar_while_busy", act, 1'b0);
        chk("ar_expected", rq_addr.size() != 0, 1'b1);
        if (rq_addr.size() != 0) a = rq_addr.pop_front();
        line = a & ~LMASK;
        off  = WRAP ? int'((a >> 2) & 32'(LW - 1)) : 0;
        chk("araddr", axi.araddr, WRAP ? (a & ~32'h3) : line);
        chk("arlen", axi.arlen, LW - 1);
        chk("arsize", axi.arsize, 3'b010);
        chk("arburst", axi.arburst, WRAP ? 2'b10 : 2'b01);
        chk("arid", axi.arid, 4'd1);
        act   = 1'b1;
        beat  = 0;
        mode  = $urandom_range(0, 5);
        ebeat = (mode == 4) ? $urandom_range(0, LW - 2)
                            : $urandom_range(0, LW - 1);
        for (int k = 0; k < LW; k++)
          e.data[k*32 +: 32] = mem_word(line + 32'(4 * k));
        e.err = (mode >= 3);
        ret_q.push_back(e);
      end
      if (ret_valid) begin
        chk("ret_expected", ret_q.size() != 0, 1'b1);
        if (ret_q.size() != 0) begin
          e = ret_q.pop_front();
          chk("ret_data", ret_data, e.data);
          chk("ret_err", ret_err, e.err);
        end
      end
    end
  end

  initial begin : w_slave
    bit            have_aw;
    bit            bdone;
    int            wb;
    int            bdly;
    logic [31:0]   aw_a;
    logic [DW-1:0] got;
    have_aw = 0; bdone = 0; wb = 0; bdly = 0;
    aw_a = '0; got = '0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 4'd1;
    forever begin
      @(negedge clk);
      if (bdone) begin
        axi.bvalid = 1'b0;
        bdone      = 1'b0;
        have_aw    = 1'b0;
      end
      axi.awready = ($urandom_range(0, 2) == 0);
      axi.wready  = 1'($urandom_range(0, 1));
      if (have_aw && wb == LW && !axi.bvalid) begin
        if (bdly == 0) begin
          axi.bvalid = 1'b1;
          axi.bresp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
        end else bdly--;
      end
      #1;
      if (axi.awvalid && axi.awready) begin
        chk("aw_outstanding", have_aw, 1'b0);
        chk("awlen", axi.awlen, LW - 1);
        chk("awsize", axi.awsize, 3'b010);
        chk("awburst", axi.awburst, 2'b01);
        chk("awid", axi.awid, 4'd1);
        have_aw = 1'b1;
        aw_a    = axi.awaddr;
        wb      = 0;
        got     = '0;
        bdly    = $urandom_range(0, 2);
      end
      if (axi.wvalid && axi.wready) begin
        chk("w_after_aw", have_aw, 1'b1);
        chk("wlast", axi.wlast, wb == LW - 1);
        chk("wstrb", axi.wstrb, 4'hF);
        chk("wid", axi.wid, 4'd1);
        if (wb < LW) got[wb*32 +: 32] = axi.wdata;
        wb++;
      end
      if (axi.bvalid && axi.bready) begin
        #1;
        chk("b_expected", wpend_tag.size() != 0, 1'b1);
        chk("w_beats", wb, LW);
        if (wpend_tag.size() != 0) begin
          chk("awaddr", aw_a, wpend_tag[0]);
          chk("wdata", got, wpend_data[0]);
          void'(wpend_tag.pop_front());
          void'(wpend_data.pop_front());
        end
        if (axi.bresp != 2'b00) exp_bus_err = 1'b1;
        bdone = 1'b1;
      end
    end
  end

  initial begin : drv
    int  r;
    bit  seen;
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_ret_valid", ret_valid, 1'b0);
    chk("rst_ret_data", ret_data, '0);
    chk("rst_crit_valid", crit_valid, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_wr_rdy", wr_rdy, 1'b1);
    chk("rst_wb_empty", wb_empty, 1'b1);
    reset = 1'b0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      r = $urandom_range(0, 3);
      rd_req  = (r == 0);
      wr_req  = (r == 1);
      rd_addr = rand_addr();
      wr_addr = rand_addr();
      for (int k = 0; k < LW; k++) wr_data[k*32 +: 32] = $urandom();
      #1;
      step_obs();
    end

    rd_req = 1'b0;
    wr_req = 1'b0;
    for (int i = 0; i < 2000 && (rd_busy || wpend_tag.size() != 0); i++) begin
      @(negedge clk);
      #1;
      step_obs();
    end
    chk("drain_done", rd_busy || wpend_tag.size() != 0, 1'b0);

    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 32'h5000_0024;
    #1;
    step_obs();
    @(negedge clk);
    rd_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (axi.rvalid && axi.rready) seen = 1'b1;
      step_obs();
      @(negedge clk);
    end
    chk("mid_burst_seen", seen, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_rd_rdy", rd_rdy, 1'b1);
    chk("mrst_rready", axi.rready, 1'b0);
    chk("mrst_arvalid", axi.arvalid, 1'b0);
    chk("mrst_ret_valid", ret_valid, 1'b0);
    chk("mrst_ret_data", ret_data, '0);
    chk("mrst_wb_empty", wb_empty, 1'b1);
    chk("mrst_wr_rdy", wr_rdy, 1'b1);
    chk("mrst_bus_err", bus_err, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
